// File: rtl/stream_classifier_pkg.sv
// Shared types and helpers for the stream classifier harness.
//   state_t    : harness FSM states (COLLECT -> WAIT -> HOLD -> COLLECT)
//   clog2_min1 : $clog2 clamped to at least 1 bit, used to size the
//                attribute index (IDX_W) and the latency counter (LAT_W)
package stream_classifier_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : increment request (ignored once count is all ones)
//   count    : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stream_classifier_harness.sv
// Feeds a flat-input classifier from a beat-serial attribute stream, waits
// the classifier latency, returns the result over valid/ready and scores it
// against a golden label.
// Ports:
//   s_valid/s_ready/s_data/s_last/s_label : attribute stream in (label on last beat)
//   cls_inp / cls_out                     : classifier input vector / result
//   m_valid/m_ready/m_result/m_match      : result handoff
//   clr_cnt                               : synchronous clear of statistics
//   sample_cnt/match_cnt/err_framing      : statistics and sticky framing error
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Valid, once raised, holds with its payload stable until that
// edge; ready may be driven combinationally from the state.
module stream_classifier_harness
  import stream_classifier_pkg::*;
#(
  parameter int NUM_A       = 9,
  parameter int WIDTH_A     = 4,
  parameter int OUTWIDTH    = 22,
  parameter int CLS_LATENCY = 0,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH_A-1:0]       s_data,
  input  logic                     s_last,
  input  logic [OUTWIDTH-1:0]      s_label,
  output logic [NUM_A*WIDTH_A-1:0] cls_inp,
  input  logic [OUTWIDTH-1:0]      cls_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUTWIDTH-1:0]      m_result,
  output logic                     m_match,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     err_framing
);

  localparam int IDX_W = clog2_min1(NUM_A);
  localparam int LAT_W = clog2_min1(CLS_LATENCY + 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [LAT_W-1:0]    wait_cnt;
  logic [OUTWIDTH-1:0] label;
  logic                beat, last_slot, frame_err, good_last, lat_done, handoff;

  assign beat      = s_valid && (state == COLLECT);
  assign last_slot = (idx == IDX_W'(NUM_A - 1));
  // s_last must coincide exactly with the final slot; anything else is a framing error
  assign frame_err = beat && (s_last != last_slot);
  assign good_last = beat && s_last && last_slot;
  assign lat_done  = (wait_cnt == LAT_W'(CLS_LATENCY));
  assign handoff   = (state == HOLD) && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      COLLECT: begin
        s_ready = 1'b1;
        if (good_last) state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_done) state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Attribute assembly, label capture and latency counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      cls_inp  <= '0;
      label    <= '0;
      wait_cnt <= '0;
      m_result <= '0;
      m_match  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          wait_cnt <= '0;
          if (beat) begin
            for (int i = 0; i < NUM_A; i++) begin
              if (idx == IDX_W'(i)) cls_inp[i*WIDTH_A +: WIDTH_A] <= s_data;
            end
            if (frame_err || good_last) idx <= '0;
            else                        idx <= idx + IDX_W'(1);
            if (good_last) label <= s_label;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + LAT_W'(1);
          if (lat_done) begin
            m_result <= cls_out;
            m_match  <= (cls_out == label);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_framing <= 1'b0;
    else if (clr_cnt)   err_framing <= 1'b0;
    else if (frame_err) err_framing <= 1'b1;
  end

  sat_counter #(.WIDTH(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (handoff),
    .count (sample_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (handoff && m_match),
    .count (match_cnt)
  );

endmodule

// File: tb/tb_stream_classifier_harness.sv
module tb_stream_classifier_harness;

  localparam int NUM_A = 9;
  localparam int WA    = 4;
  localparam int OW    = 22;
  localparam int LAT   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  s_valid = 1'b0;
  logic [WA-1:0]         s_data  = '0;
  logic                  s_last  = 1'b0;
  logic [OW-1:0]         s_label = '0;
  logic                  m_ready = 1'b1;
  logic                  clr_cnt = 1'b0;
  logic [OW-1:0]         cls_out;

  logic                  s_ready, m_valid, m_match, err_framing;
  logic [NUM_A*WA-1:0]   cls_inp;
  logic [OW-1:0]         m_result;
  logic [15:0]           sample_cnt, match_cnt;

  // second instance with 2-bit counters, same stimulus, for saturation
  logic                  s_ready2, m_valid2, m_match2, err_framing2;
  logic [NUM_A*WA-1:0]   cls_inp2;
  logic [OW-1:0]         m_result2;
  logic [1:0]            sample_cnt2, match_cnt2;

  stream_classifier_harness #(.CLS_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_label(s_label), .cls_inp(cls_inp), .cls_out(cls_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_match(m_match),
    .clr_cnt(clr_cnt), .sample_cnt(sample_cnt), .match_cnt(match_cnt),
    .err_framing(err_framing)
  );

  stream_classifier_harness #(.CLS_LATENCY(LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .s_label(s_label), .cls_inp(cls_inp2), .cls_out(cls_out),
    .m_valid(m_valid2), .m_ready(m_ready), .m_result(m_result2), .m_match(m_match2),
    .clr_cnt(clr_cnt), .sample_cnt(sample_cnt2), .match_cnt(match_cnt2),
    .err_framing(err_framing2)
  );

  // classifier stub: zero-extended attribute sum, two register stages
  logic [OW-1:0] sum_c, p1, p2;
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_A; i++) sum_c = sum_c + OW'(cls_inp[i*WA +: WA]);
  end
  always_ff @(posedge clk) begin
    p1 <= sum_c;
    p2 <= p1;
  end
  assign cls_out = p2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: send nbeats beats, s_last on the final one
  task automatic send_sample(input logic [35:0] attrs, input int nbeats, input logic [OW-1:0] lbl);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      s_valid = 1'b1;
      s_data  = attrs[i*WA +: WA];
      s_last  = (i == nbeats - 1);
      s_label = lbl;
      n = 0;
      while (!s_ready && n < 50) begin
        tick();
        n++;
      end
      if (n == 50) check("s_ready_timeout", 64'(s_ready), 64'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // cycles from last-beat handshake until m_valid (bounded)
  task automatic wait_result(output int n);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    check("result_timeout", 64'(m_valid), 64'd1);
  endtask

  // full sample with m_ready=1: latency, result, match, then handoff
  task automatic run_good(input string tag, input logic [35:0] attrs, input logic [OW-1:0] lbl,
                          input logic [OW-1:0] exp_res, input logic exp_match);
    int n;
    send_sample(attrs, NUM_A, lbl);
    wait_result(n);
    check({tag, "_latency"}, 64'(n), 64'(LAT + 1));
    check({tag, "_result"}, 64'(m_result), 64'(exp_res));
    check({tag, "_match"}, 64'(m_match), 64'(exp_match));
    check({tag, "_s_ready_hold"}, 64'(s_ready), 64'd0);
    tick();
    check({tag, "_m_valid_drop"}, 64'(m_valid), 64'd0);
  endtask

  initial begin : stimulus
    int  n;
    logic saw, stable;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_result", 64'(m_result), 64'd0);
    check("rst_cls_inp", 64'(cls_inp), 64'd0);
    check("rst_counts", {32'(sample_cnt), 32'(match_cnt)}, 64'd0);
    check("rst_err", 64'(err_framing), 64'd0);
    rst = 1'b0;
    tick();

    // attributes 1..9, label 45
    run_good("s1", 36'h987654321, 22'd45, 22'd45, 1'b1);
    check("s1_cls_inp", 64'(cls_inp), 64'h987654321);
    check("s1_counts", {32'(sample_cnt), 32'(match_cnt)}, {32'd1, 32'd1});
    check("s1_bubble_s_ready", 64'(s_ready), 64'd1);

    // all 15, label 0
    run_good("s2", 36'hFFFFFFFFF, 22'd0, 22'd135, 1'b0);
    check("s2_counts", {32'(sample_cnt), 32'(match_cnt)}, {32'd2, 32'd1});

    // framing error: s_last on 5th beat
    send_sample(36'h987654321, 5, 22'd15);
    check("frm_err", 64'(err_framing), 64'd1);
    saw = 1'b0;
    repeat (6) begin
      tick();
      saw = saw | m_valid;
    end
    check("frm_no_result", 64'(saw), 64'd0);
    check("frm_s_ready", 64'(s_ready), 64'd1);
    run_good("s3", 36'h222222222, 22'd18, 22'd18, 1'b1);
    check("s3_counts", {32'(sample_cnt), 32'(match_cnt)}, {32'd3, 32'd2});

    // backpressure in HOLD
    m_ready = 1'b0;
    send_sample(36'h876543210, NUM_A, 22'd36);
    wait_result(n);
    check("bp_latency", 64'(n), 64'(LAT + 1));
    stable = 1'b1;
    repeat (10) begin
      tick();
      stable = stable & m_valid & (m_result == 22'd36) & m_match & ~s_ready
               & (sample_cnt == 16'd3) & (match_cnt == 16'd2);
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    m_ready = 1'b1;
    tick();
    check("bp_counts", {32'(sample_cnt), 32'(match_cnt)}, {32'd4, 32'd3});
    check("bp_m_valid_drop", 64'(m_valid), 64'd0);

    // reset during WAIT
    send_sample(36'h987654321, NUM_A, 22'd45);
    tick();
    rst = 1'b1;
    #1;
    check("mrst_m_valid", 64'(m_valid), 64'd0);
    check("mrst_s_ready", 64'(s_ready), 64'd1);
    check("mrst_outs", {30'(m_result), 1'(m_match), 1'(err_framing), 32'(cls_inp)}, 64'd0);
    check("mrst_counts", {32'(sample_cnt), 32'(match_cnt)}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    saw = 1'b0;
    repeat (4) begin
      tick();
      saw = saw | m_valid;
    end
    check("mrst_abandoned", 64'(saw), 64'd0);
    run_good("s4", 36'h987654321, 22'd45, 22'd45, 1'b1);
    check("s4_counts", {32'(sample_cnt), 32'(match_cnt)}, {32'd1, 32'd1});

    // framing error, then clr_cnt coincident with handoff
    send_sample(36'h111111111, 3, 22'd3);
    check("frm2_err", 64'(err_framing), 64'd1);
    send_sample(36'h987654321, NUM_A, 22'd45);
    wait_result(n);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_counts", {32'(sample_cnt), 32'(match_cnt)}, 64'd0);
    check("clr_err", 64'(err_framing), 64'd0);
    check("clr_m_valid_drop", 64'(m_valid), 64'd0);

    // saturation on the 2-bit instance
    repeat (5) run_good("sat", 36'h987654321, 22'd45, 22'd45, 1'b1);
    check("sat_cnt2", {32'(sample_cnt2), 32'(match_cnt2)}, {32'd3, 32'd3});
    check("sat_cnt16", {32'(sample_cnt), 32'(match_cnt)}, {32'd5, 32'd5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
